// File: rtl/arb_pkg.sv
// Shared definitions for the 4-way round-robin packet arbiter.
package arb_pkg;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned GRANT_W = 2;

  // FSM state encoding
  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  // First requester with valid set, searching upward from ptr with wrap.
  // Callers only use the result when at least one request is pending.
  function automatic logic [GRANT_W-1:0] rr_pick(
    input logic [NUM_REQ-1:0] req,
    input logic [GRANT_W-1:0] ptr
  );
    logic [GRANT_W-1:0] idx;
    logic               found;
    rr_pick = ptr;
    found   = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = ptr + GRANT_W'(k);
      if (!found && req[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/mux4.sv
// Generic 4:1 payload multiplexer.
module mux4 #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [1:0]       sel,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  output logic [WIDTH-1:0] y
);

  // Select one of four inputs
  always_comb begin
    y = d0;
    case (sel)
      2'd1:    y = d1;
      2'd2:    y = d2;
      2'd3:    y = d3;
      default: y = d0;
    endcase
  end

endmodule

// File: rtl/rr_arb4.sv
// Round-robin arbiter merging four packet streams onto one channel.
// A grant is held for the whole packet and released after the last beat.
module rr_arb4
  import arb_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [WIDTH-1:0]     i_data0,
  input  logic [WIDTH-1:0]     i_data1,
  input  logic [WIDTH-1:0]     i_data2,
  input  logic [WIDTH-1:0]     i_data3,
  input  logic [NUM_REQ-1:0]   i_req_valid,
  input  logic [NUM_REQ-1:0]   i_req_last,
  output logic [NUM_REQ-1:0]   o_req_ready,
  output logic                 o_valid,
  output logic [WIDTH-1:0]     o_data,
  output logic                 o_last,
  input  logic                 i_ready,
  output logic [GRANT_W-1:0]   o_grant,
  output logic                 o_busy
);

  logic [0:0]         state_q, state_d;
  logic [GRANT_W-1:0] grant_q, grant_d;
  logic [GRANT_W-1:0] ptr_q,   ptr_d;
  logic               xfer;
  logic [WIDTH-1:0]   mux_y;

  // Payload path follows the grant register
  mux4 #(
    .WIDTH (WIDTH)
  ) u_mux4 (
    .sel (grant_q),
    .d0  (i_data0),
    .d1  (i_data1),
    .d2  (i_data2),
    .d3  (i_data3),
    .y   (mux_y)
  );

  // State, grant and round-robin pointer registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
    end
  end

  // Next-state logic and channel outputs; outputs follow the current state
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    ptr_d       = ptr_q;
    xfer        = 1'b0;
    o_valid     = 1'b0;
    o_last      = 1'b0;
    o_data      = '0;
    o_req_ready = '0;
    o_busy      = 1'b0;

    if (state_q == ST_LOCKED) begin
      o_valid              = i_req_valid[grant_q];
      o_last               = i_req_last[grant_q];
      o_data               = mux_y;
      o_busy               = 1'b1;
      o_req_ready[grant_q] = i_ready;
      xfer                 = i_req_valid[grant_q] && i_ready;
      if (xfer && i_req_last[grant_q]) begin
        state_d = ST_IDLE;
        ptr_d   = grant_q + GRANT_W'(1);
      end
    end else begin
      if (|i_req_valid) begin
        grant_d = rr_pick(i_req_valid, ptr_q);
        state_d = ST_LOCKED;
      end
    end
  end

  assign o_grant = grant_q;

endmodule

// File: tb/tb_rr_arb4.sv
// Directed and randomized checks for the round-robin packet arbiter.
module tb_rr_arb4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] d0, d1, d2, d3;
  logic [3:0]  vld, lst;
  logic        rdy;
  logic [3:0]  o_req_ready;
  logic        o_valid, o_last, o_busy;
  logic [31:0] o_data;
  logic [1:0]  o_grant;

  int nchecks = 0;
  int nerrs   = 0;

  always #5 clk = ~clk;

  rr_arb4 #(.WIDTH(32)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_data0     (d0),
    .i_data1     (d1),
    .i_data2     (d2),
    .i_data3     (d3),
    .i_req_valid (vld),
    .i_req_last  (lst),
    .o_req_ready (o_req_ready),
    .o_valid     (o_valid),
    .o_data      (o_data),
    .o_last      (o_last),
    .i_ready     (rdy),
    .o_grant     (o_grant),
    .o_busy      (o_busy)
  );

  typedef struct {
    logic [3:0]  valid;
    logic [3:0]  last;
    logic        ready;
    logic        ev;
    logic        el;
    logic [3:0]  er;
    logic [1:0]  eg;
    logic        eb;
    logic [31:0] ed;
  } vec_t;

  function automatic vec_t mk(input logic [3:0] valid, input logic [3:0] last, input logic ready,
                              input logic ev, input logic el, input logic [3:0] er,
                              input logic [1:0] eg, input logic eb, input logic [31:0] ed);
    vec_t v;
    v.valid = valid; v.last = last; v.ready = ready;
    v.ev = ev; v.el = el; v.er = er; v.eg = eg; v.eb = eb; v.ed = ed;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrs++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic ev, input logic el, input logic [3:0] er,
                         input logic [1:0] eg, input logic eb, input logic [31:0] ed);
    chk({tag, ".valid"}, 32'(o_valid), 32'(ev));
    chk({tag, ".last"},  32'(o_last),  32'(el));
    chk({tag, ".ready"}, 32'(o_req_ready), 32'(er));
    chk({tag, ".grant"}, 32'(o_grant), 32'(eg));
    chk({tag, ".busy"},  32'(o_busy),  32'(eb));
    chk({tag, ".data"},  o_data, ed);
  endtask

  // Apply inputs just after a rising edge, then wait for the falling edge to sample
  task automatic step(input logic [3:0] valid, input logic [3:0] last, input logic ready);
    @(posedge clk);
    #1;
    vld = valid; lst = last; rdy = ready;
    @(negedge clk);
  endtask

  vec_t        tbl[11];
  logic [31:0] dv[4];
  int          sent[4], rx[4], bl[4], waitc[4];
  bit          active[4], started[4];
  bit          lastrec[4][0:4095];
  logic [3:0]  xfer, exp_x;
  int          g, total;

  initial begin
    rst_n = 1'b0;
    vld = 4'b1111; lst = 4'b1111; rdy = 1'b1;
    d0 = 32'd10; d1 = 32'd20; d2 = 32'd30; d3 = 32'd40;
    #2;
    chk_all("reset", 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0, 32'd0);
    vld = 4'b0000;
    #10;
    rst_n = 1'b1;

    // Single-beat packets from all four requesters rotate with one idle cycle between
    tbl[0]  = mk(4'b1111, 4'b1111, 1'b1, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0, 32'd0);
    tbl[1]  = mk(4'b1111, 4'b1111, 1'b1, 1'b1, 1'b1, 4'b0001, 2'd0, 1'b1, 32'd10);
    tbl[2]  = mk(4'b1111, 4'b1111, 1'b1, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0, 32'd0);
    tbl[3]  = mk(4'b1111, 4'b1111, 1'b1, 1'b1, 1'b1, 4'b0010, 2'd1, 1'b1, 32'd20);
    tbl[4]  = mk(4'b1111, 4'b1111, 1'b1, 1'b0, 1'b0, 4'b0000, 2'd1, 1'b0, 32'd0);
    tbl[5]  = mk(4'b1111, 4'b1111, 1'b1, 1'b1, 1'b1, 4'b0100, 2'd2, 1'b1, 32'd30);
    tbl[6]  = mk(4'b1111, 4'b1111, 1'b1, 1'b0, 1'b0, 4'b0000, 2'd2, 1'b0, 32'd0);
    tbl[7]  = mk(4'b1111, 4'b1111, 1'b1, 1'b1, 1'b1, 4'b1000, 2'd3, 1'b1, 32'd40);
    tbl[8]  = mk(4'b1111, 4'b1111, 1'b1, 1'b0, 1'b0, 4'b0000, 2'd3, 1'b0, 32'd0);
    tbl[9]  = mk(4'b1111, 4'b1111, 1'b1, 1'b1, 1'b1, 4'b0001, 2'd0, 1'b1, 32'd10);
    tbl[10] = mk(4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0, 32'd0);

    for (int i = 0; i < 11; i++) begin
      step(tbl[i].valid, tbl[i].last, tbl[i].ready);
      chk_all($sformatf("rot[%0d]", i), tbl[i].ev, tbl[i].el, tbl[i].er, tbl[i].eg, tbl[i].eb, tbl[i].ed);
    end

    // Requester 1 holds a 3-beat packet while requester 0 keeps requesting
    d0 = 32'd100; d1 = 32'd101;
    step(4'b0011, 4'b0000, 1'b1);
    chk_all("lock.idle", 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0, 32'd0);
    step(4'b0011, 4'b0000, 1'b1);
    chk_all("lock.b1", 1'b1, 1'b0, 4'b0010, 2'd1, 1'b1, 32'd101);
    d1 = 32'd102;
    step(4'b0011, 4'b0000, 1'b1);
    chk_all("lock.b2", 1'b1, 1'b0, 4'b0010, 2'd1, 1'b1, 32'd102);
    d1 = 32'd103;
    step(4'b0011, 4'b0010, 1'b1);
    chk_all("lock.b3", 1'b1, 1'b1, 4'b0010, 2'd1, 1'b1, 32'd103);
    step(4'b1001, 4'b0000, 1'b1);
    chk_all("lock.gap", 1'b0, 1'b0, 4'b0000, 2'd1, 1'b0, 32'd0);

    // Next grant skips idle requester 2 and goes to 3; then backpressure
    d3 = 32'd300;
    for (int i = 0; i < 5; i++) begin
      step(4'b1001, 4'b0000, 1'b0);
      chk_all($sformatf("bp[%0d]", i), 1'b1, 1'b0, 4'b0000, 2'd3, 1'b1, 32'd300);
    end
    step(4'b0001, 4'b0000, 1'b1);
    chk_all("stall", 1'b0, 1'b0, 4'b1000, 2'd3, 1'b1, 32'd300);
    step(4'b1001, 4'b1000, 1'b1);
    chk_all("resume", 1'b1, 1'b1, 4'b1000, 2'd3, 1'b1, 32'd300);
    step(4'b0000, 4'b0000, 1'b1);
    chk_all("idle.a", 1'b0, 1'b0, 4'b0000, 2'd3, 1'b0, 32'd0);
    step(4'b0010, 4'b0010, 1'b1);
    chk_all("idle.b", 1'b0, 1'b0, 4'b0000, 2'd3, 1'b0, 32'd0);
    step(4'b0010, 4'b0010, 1'b1);
    chk_all("r1.single", 1'b1, 1'b1, 4'b0010, 2'd1, 1'b1, 32'd103);
    step(4'b0100, 4'b0000, 1'b1);
    chk_all("r2.idle", 1'b0, 1'b0, 4'b0000, 2'd1, 1'b0, 32'd0);
    d2 = 32'd222;
    step(4'b0101, 4'b0000, 1'b1);
    chk_all("r2.b1", 1'b1, 1'b0, 4'b0100, 2'd2, 1'b1, 32'd222);

    // Asynchronous reset between edges mid-packet, then requester 0 wins over 2
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("rst_async", 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0, 32'd0);
    #1;
    rst_n = 1'b1;
    step(4'b0101, 4'b0000, 1'b1);
    chk_all("post_rst", 1'b1, 1'b0, 4'b0001, 2'd0, 1'b1, 32'd100);

    // Randomized traffic with per-requester ordered streams
    rst_n = 1'b0;
    vld = 4'b0000; lst = 4'b0000;
    #3;
    rst_n = 1'b1;
    xfer = 4'b0000;
    for (int n = 0; n < 4; n++) begin
      sent[n] = 0; rx[n] = 0; bl[n] = 0; waitc[n] = 0;
      active[n] = 1'b0; started[n] = 1'b0;
    end
    for (int c = 0; c < 1500; c++) begin
      @(posedge clk);
      #1;
      for (int n = 0; n < 4; n++) begin
        if (xfer[n]) begin
          sent[n]++;
          bl[n]--;
          if (!started[n]) waitc[n] = 0;
          started[n] = 1'b1;
          if (bl[n] == 0) begin
            active[n]  = 1'b0;
            started[n] = 1'b0;
          end
        end
        if (!active[n] && $urandom_range(2) == 0) begin
          active[n]  = 1'b1;
          bl[n]      = int'($urandom_range(4, 1));
          started[n] = 1'b0;
        end
        lastrec[n][sent[n]] = (bl[n] == 1);
        dv[n]  = {8'(n), 24'(sent[n])};
        vld[n] = active[n] && (!started[n] || $urandom_range(3) != 0);
        lst[n] = active[n] && (bl[n] == 1);
      end
      d0 = dv[0]; d1 = dv[1]; d2 = dv[2]; d3 = dv[3];
      rdy = ($urandom_range(3) != 0);
      @(negedge clk);
      xfer  = vld & o_req_ready;
      exp_x = (o_valid && rdy) ? (4'b0001 << o_grant) : 4'b0000;
      chk("rand.xfer", 32'(xfer), 32'(exp_x));
      if (o_valid && rdy) begin
        g = int'(o_grant);
        chk("rand.data", o_data, {8'(g), 24'(rx[g])});
        chk("rand.last", 32'(o_last), 32'(lastrec[g][rx[g]]));
        rx[g]++;
        if (o_last) begin
          for (int n = 0; n < 4; n++) begin
            if (n != g && vld[n] && !started[n]) begin
              waitc[n]++;
              chk("rand.starve", 32'(waitc[n] <= 3), 32'd1);
            end
          end
        end
      end
    end
    total = rx[0] + rx[1] + rx[2] + rx[3];
    chk("rand.progress", 32'(total > 200), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrs);
    $finish;
  end

endmodule
